decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised RV32I/RV64I decode stage between fetch and register-read/execute.
- Accepts an instruction and its PC over a valid/ready handshake and splits it into fields.
- Classifies the instruction format, generates the sign-extended immediate and flags illegal encodings.
- Presents the result from a registered output stage backed by a one-entry skid buffer, with pipeline flush support.

Parameters:
- XLEN, 32, datapath width for immediate and PC; legal values 32 or 64.
- RESET_PC_TAG, 0, value driven on out_pc during and after reset, until the first output is loaded.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  PC of in_instr.
- flush  input  1  discard all held and incoming instructions.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  downstream accepts.
- out_pc  output  XLEN  PC of the decoded instruction.
- out_opcode  output  7  instr[6:0].
- out_rd  output  5  instr[11:7].
- out_rs1  output  5  instr[19:15].
- out_rs2  output  5  instr[24:20].
- out_funct3  output  3  instr[14:12].
- out_funct7  output  7  instr[31:25].
- out_fmt  output  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_imm  output  XLEN  immediate, sign-extended to XLEN; 0 for R and NONE.
- out_rd_we  output  1  instruction writes rd; forced 0 when rd==0.
- out_illegal  output  1  illegal encoding.

Behaviour:
- Decode is combinational on the input side. All out_* signals come from registers.
- Opcode map:
  - 0110111 LUI and 0010111 AUIPC: U format.
  - 1101111 JAL: J format.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 1110011 SYSTEM: I format.
  - 1100011 BRANCH: B format.
  - 0100011 STORE: S format.
  - 0110011 OP: R format.
  - 0001111 MISC-MEM: I format, with out_rd_we forced 0.
- Illegal encodings: instr[1:0]!=2'b11, or an opcode not in the map. An illegal instruction gets fmt=NONE, imm=0, rd_we=0, illegal=1. It still passes through the handshake and is never dropped.
- Immediates:
  - I: {instr[31:20]}.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - All immediates are sign-extended from instr[31] to XLEN. For XLEN=64, U is sign-extended from bit 31.
- rd_we=1 for R, I (except MISC-MEM, and except SYSTEM with funct3==0), U and J formats. rd_we=0 for S and B.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Latency: one cycle from input transfer to out_valid when the output register is free.
- Output register load:
  - If the output register is empty, or is transferring this cycle, it loads from the skid buffer when skid_valid is set, else from the input.
  - If the output register is full and stalled (out_valid & !out_ready), an accepted input is decoded and written into the skid buffer.
- Ordering is strictly FIFO. Throughput is one instruction per cycle while out_ready=1.
- in_ready depends only on registered skid_valid; there is no combinational path from out_ready.
- Flush (registered effect):
  - out_valid and skid_valid clear on the next edge.
  - An input transferred in the flush cycle is discarded.
  - Flush has priority over simultaneous loads.
  - Data registers need not clear.
- Reset (rst_n=0): out_valid=0, skid_valid=0 (so in_ready=1), out_pc=RESET_PC_TAG. All other outputs are 0, including fmt (R). Reset mid-stream drops all held instructions. Release of rst_n is synchronised by the reset owner.
- Output data stays stable while out_valid & !out_ready.

Test Plan:
- Reset then in_instr=0x00500093 (addi x1,x0,5), pc=0x100, out_ready=1 -> next cycle out_valid=1, fmt=1, rd=1, imm=5, rd_we=1, pc=0x100.
- Back-to-back stream 0xFE000EE3 (beq, B), 0x000012B7 (lui x5,1), 0x00112023 (sw, S) -> imm=0xFFFFFFFC, 0x00001000, 0; rd_we=0,1,0; one output per cycle.
- Hold out_ready=0 with a stream of 3 instructions -> 2 are held, in_ready drops after the second acceptance, order is preserved after out_ready=1, no loss or duplication.
- Flush while both entries are full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed PCs never appear at the output.
- in_instr=0x00000000 and 0x0000007F -> illegal=1, fmt=7, imm=0, rd_we=0, output still valid.
- XLEN=64: 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000; assert rst_n low mid-stall -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   RV32I/RV64I instruction decode stage sitting between fetch and
//   register-read/execute. An instruction and its PC arrive over a
//   valid/ready handshake. The instruction is split into its fields, its
//   format is classified, the sign-extended immediate is built and illegal
//   encodings are flagged. The decoded result is presented from a registered
//   output stage backed by a one-entry skid buffer, so in_ready never depends
//   combinationally on out_ready. A flush discards everything held plus any
//   instruction accepted in the flush cycle.
//
// Parameters:
//   XLEN          datapath width of PC and immediate (32 or 64)
//   RESET_PC_TAG  value shown on out_pc from reset until the first load
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     fetch presents an instruction
//   in_ready     stage can accept (skid buffer empty)
//   in_instr     raw 32-bit instruction word
//   in_pc        PC of in_instr
//   flush        drop held and incoming instructions
//   out_valid    decoded instruction available
//   out_ready    downstream accepts
//   out_pc       PC of decoded instruction
//   out_opcode   instr[6:0]
//   out_rd       instr[11:7]
//   out_rs1      instr[19:15]
//   out_rs2      instr[24:20]
//   out_funct3   instr[14:12]
//   out_funct7   instr[31:25]
//   out_fmt      R=0 I=1 S=2 B=3 U=4 J=5 NONE=7
//   out_imm      sign-extended immediate (0 for R and NONE)
//   out_rd_we    instruction writes rd (never for rd==0)
//   out_illegal  illegal encoding
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  // One decoded instruction as held by either the output register or the
  // skid buffer. The raw word is kept so the field outputs are plain slices.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  fmt_e            w_fmt;
  logic            w_no_rd;
  logic            w_illegal;
  logic            w_rd_we;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  entry_t          w_dec;
  logic            w_in_fire;
  logic            w_out_free;

  entry_t          r_out;
  entry_t          r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_funct3 = in_instr[14:12];

  // Every immediate is sign-extended from instr[31]; the signed size cast
  // does the extension, which also covers U-type on RV64.
  assign w_imm_i = XLEN'($signed(in_instr[31:20]));
  assign w_imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

  // Format classification from the opcode. Anything not in the map, or a
  // word whose low two bits are not 11 (compressed space), is illegal.
  // w_no_rd marks the I-format opcodes that never write rd: fences, and
  // SYSTEM with funct3==0 (ecall/ebreak/xret).
  always_comb begin
    w_fmt   = FMT_NONE;
    w_no_rd = 1'b0;
    if (in_instr[1:0] == 2'b11) begin
      case (w_opcode)
        OP_LUI, OP_AUIPC:          w_fmt = FMT_U;
        OP_JAL:                    w_fmt = FMT_J;
        OP_JALR, OP_LOAD, OP_IMM:  w_fmt = FMT_I;
        OP_SYSTEM: begin
          w_fmt   = FMT_I;
          w_no_rd = (w_funct3 == 3'b000);
        end
        OP_MISCMEM: begin
          w_fmt   = FMT_I;
          w_no_rd = 1'b1;
        end
        OP_BRANCH:                 w_fmt = FMT_B;
        OP_STORE:                  w_fmt = FMT_S;
        OP_OP:                     w_fmt = FMT_R;
        default:                   w_fmt = FMT_NONE;
      endcase
    end
    w_illegal = (w_fmt == FMT_NONE);
  end

  // Immediate selection by format; R and illegal words carry no immediate.
  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I:   w_imm = w_imm_i;
      FMT_S:   w_imm = w_imm_s;
      FMT_B:   w_imm = w_imm_b;
      FMT_U:   w_imm = w_imm_u;
      FMT_J:   w_imm = w_imm_j;
      default: w_imm = '0;
    endcase
  end

  // Register write enable: formats that produce a result write rd, except
  // the no-rd opcodes above, and a write to x0 is never reported.
  always_comb begin
    w_rd_we = 1'b0;
    case (w_fmt)
      FMT_R, FMT_I, FMT_U, FMT_J: w_rd_we = 1'b1;
      default:                    w_rd_we = 1'b0;
    endcase
    if (w_no_rd || (w_rd == 5'd0)) begin
      w_rd_we = 1'b0;
    end
  end

  assign w_dec = '{pc:      in_pc,
                   instr:   in_instr,
                   fmt:     w_fmt,
                   imm:     w_imm,
                   rd_we:   w_rd_we,
                   illegal: w_illegal};

  // in_ready is purely the registered skid state, so there is no path from
  // out_ready back to fetch. The output register may be reloaded whenever it
  // is empty or is being consumed this cycle.
  assign in_ready   = ~r_skid_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  // Occupancy of the two slots. The skid only fills while the output is
  // stalled and always drains into the output first, which keeps FIFO order.
  // Flush wins over any load, including the input accepted in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid  <= r_skid_valid | w_in_fire;
      r_skid_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Payload movement mirrors the occupancy block. Data is left untouched on
  // flush and while stalled, so the output stays stable until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '{pc: RESET_PC_TAG, default: '0};
      r_skid <= '0;
    end else if (!flush) begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out <= r_skid;
        end else if (w_in_fire) begin
          r_out <= w_dec;
        end
      end else if (w_in_fire) begin
        r_skid <= w_dec;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out.pc;
  assign out_opcode  = r_out.instr[6:0];
  assign out_rd      = r_out.instr[11:7];
  assign out_funct3  = r_out.instr[14:12];
  assign out_rs1     = r_out.instr[19:15];
  assign out_rs2     = r_out.instr[24:20];
  assign out_funct7  = r_out.instr[31:25];
  assign out_fmt     = r_out.fmt;
  assign out_imm     = r_out.imm;
  assign out_rd_we   = r_out.rd_we;
  assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   localparam logic [31:0] TAG32 = 32'hDEAD_0000;
   localparam logic [63:0] TAG64 = 64'hCAFE_0000_DEAD_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inValid;
   logic [31:0] inInstr;
   logic [63:0] inPc;
   logic        outReady;
   logic        flushIn;

   logic        o32InReady, o32Valid, o32RdWe, o32Illegal;
   logic [31:0] o32Pc, o32Imm;
   logic [6:0]  o32Opcode, o32Funct7;
   logic [4:0]  o32Rd, o32Rs1, o32Rs2;
   logic [2:0]  o32Funct3, o32Fmt;

   logic        o64InReady, o64Valid, o64RdWe, o64Illegal;
   logic [63:0] o64Pc, o64Imm;
   logic [6:0]  o64Opcode, o64Funct7;
   logic [4:0]  o64Rd, o64Rs1, o64Rs2;
   logic [2:0]  o64Funct3, o64Fmt;

   int nCmp = 0;
   int nFail = 0;

   // Expected contents of the stage, oldest first: {pc, instr}.
   logic [95:0] q[$];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(o32InReady),
      .in_instr(inInstr), .in_pc(inPc[31:0]), .flush(flushIn),
      .out_valid(o32Valid), .out_ready(outReady), .out_pc(o32Pc),
      .out_opcode(o32Opcode), .out_rd(o32Rd), .out_rs1(o32Rs1), .out_rs2(o32Rs2),
      .out_funct3(o32Funct3), .out_funct7(o32Funct7), .out_fmt(o32Fmt),
      .out_imm(o32Imm), .out_rd_we(o32RdWe), .out_illegal(o32Illegal)
   );

   decode_stage #(.XLEN(64), .RESET_PC_TAG(TAG64)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(o64InReady),
      .in_instr(inInstr), .in_pc(inPc), .flush(flushIn),
      .out_valid(o64Valid), .out_ready(outReady), .out_pc(o64Pc),
      .out_opcode(o64Opcode), .out_rd(o64Rd), .out_rs1(o64Rs1), .out_rs2(o64Rs2),
      .out_funct3(o64Funct3), .out_funct7(o64Funct7), .out_fmt(o64Fmt),
      .out_imm(o64Imm), .out_rd_we(o64RdWe), .out_illegal(o64Illegal)
   );

   // Single comparison point: every check in the bench goes through here.
   task automatic cmp(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCmp++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference decode written from the ISA rules: format by opcode, then the
   // immediate as a signed value (scaled where the encoding drops low zeros).
   task automatic refDecode(input logic [31:0] ins, output logic [2:0] fmt,
                            output logic [63:0] imm, output logic we, output logic ill);
      longint v;
      logic [6:0] op;
      op  = ins[6:0];
      ill = 1'b0;
      case (op)
         7'h37, 7'h17:                      fmt = 3'd4;
         7'h6F:                             fmt = 3'd5;
         7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: fmt = 3'd1;
         7'h63:                             fmt = 3'd3;
         7'h23:                             fmt = 3'd2;
         7'h33:                             fmt = 3'd0;
         default: begin fmt = 3'd7; ill = 1'b1; end
      endcase
      case (fmt)
         3'd1:    v = longint'($signed(ins[31:20]));
         3'd2:    v = longint'($signed({ins[31:25], ins[11:7]}));
         3'd3:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
         3'd4:    v = longint'($signed(ins[31:12])) * 4096;
         3'd5:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
         default: v = 0;
      endcase
      imm = 64'(v);
      we  = (fmt == 3'd0 || fmt == 3'd1 || fmt == 3'd4 || fmt == 3'd5)
            && (op != 7'h0F) && !(op == 7'h73 && ins[14:12] == 3'd0)
            && (ins[11:7] != 5'd0);
   endtask

   // Compare both DUTs against the model's view of the stage.
   task automatic checkOutput();
      logic [63:0] pc, imm;
      logic [31:0] ins;
      logic [2:0]  fmt;
      logic        we, ill, expValid, expReady;
      expValid = (q.size() > 0);
      expReady = (q.size() < 2);
      cmp("valid32", 64'(o32Valid), 64'(expValid));
      cmp("valid64", 64'(o64Valid), 64'(expValid));
      cmp("ready32", 64'(o32InReady), 64'(expReady));
      cmp("ready64", 64'(o64InReady), 64'(expReady));
      if (expValid) begin
         {pc, ins} = q[0];
         refDecode(ins, fmt, imm, we, ill);
         cmp("pc32", 64'(o32Pc), 64'(pc[31:0]));
         cmp("pc64", o64Pc, pc);
         cmp("fields32", 64'({o32Funct7, o32Rs2, o32Rs1, o32Funct3, o32Rd, o32Opcode}), 64'(ins));
         cmp("fields64", 64'({o64Funct7, o64Rs2, o64Rs1, o64Funct3, o64Rd, o64Opcode}), 64'(ins));
         cmp("fmt32", 64'(o32Fmt), 64'(fmt));
         cmp("fmt64", 64'(o64Fmt), 64'(fmt));
         cmp("imm32", 64'(o32Imm), 64'(imm[31:0]));
         cmp("imm64", o64Imm, imm);
         cmp("rdwe32", 64'(o32RdWe), 64'(we));
         cmp("rdwe64", 64'(o64RdWe), 64'(we));
         cmp("illegal32", 64'(o32Illegal), 64'(ill));
         cmp("illegal64", 64'(o64Illegal), 64'(ill));
      end
   endtask

   // One clock of stimulus: check at the falling edge, drive, then advance
   // the model across the rising edge. Returns just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                                input logic ordy, input logic fl);
      logic fire, pop;
      @(negedge clk);
      checkOutput();
      inValid  = v;
      inInstr  = ins;
      inPc     = pc;
      outReady = ordy;
      flushIn  = fl;
      fire = v && (q.size() < 2);
      pop  = (q.size() > 0) && ordy;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (fire) q.push_back({pc, ins});
      end
   endtask

   function automatic logic [31:0] randInstr();
      logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                7'h73, 7'h63, 7'h23, 7'h33, 7'h0F};
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(7) == 0) return r;
      return {r[31:7], ops[$urandom_range(10)]};
   endfunction

   task automatic checkResetState(input string tag);
      cmp({tag, "_valid32"}, 64'(o32Valid), 64'(0));
      cmp({tag, "_valid64"}, 64'(o64Valid), 64'(0));
      cmp({tag, "_ready32"}, 64'(o32InReady), 64'(1));
      cmp({tag, "_ready64"}, 64'(o64InReady), 64'(1));
      cmp({tag, "_pc32"}, 64'(o32Pc), 64'(TAG32));
      cmp({tag, "_pc64"}, o64Pc, TAG64);
   endtask

   initial begin
      rst_n    = 1'b1;
      inValid  = 1'b0;
      inInstr  = '0;
      inPc     = '0;
      outReady = 1'b0;
      flushIn  = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      checkResetState("reset");
      cmp("reset_rest32", 64'({o32Opcode, o32Rd, o32Rs1, o32Rs2, o32Funct3, o32Funct7,
                               o32Fmt, o32RdWe, o32Illegal}), 64'(0));
      cmp("reset_imm32", 64'(o32Imm), 64'(0));
      cmp("reset_imm64", o64Imm, 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] addi x1,x0,5");
      applyStimulus(1, 32'h0050_0093, 64'h100, 1, 0);
      #1;
      cmp("addi_valid", 64'(o32Valid), 64'(1));
      cmp("addi_fmt", 64'(o32Fmt), 64'(1));
      cmp("addi_rd", 64'(o32Rd), 64'(1));
      cmp("addi_imm", 64'(o32Imm), 64'(5));
      cmp("addi_rdwe", 64'(o32RdWe), 64'(1));
      cmp("addi_pc", 64'(o32Pc), 64'h100);

      $display("[TB] back-to-back beq/lui/sw");
      applyStimulus(1, 32'hFE00_0EE3, 64'h104, 1, 0);
      #1;
      cmp("beq_imm32", 64'(o32Imm), 64'hFFFF_FFFC);
      cmp("beq_imm64", o64Imm, 64'hFFFF_FFFF_FFFF_FFFC);
      cmp("beq_rdwe", 64'(o32RdWe), 64'(0));
      applyStimulus(1, 32'h0000_12B7, 64'h108, 1, 0);
      #1;
      cmp("lui_imm", 64'(o32Imm), 64'h1000);
      cmp("lui_rdwe", 64'(o32RdWe), 64'(1));
      applyStimulus(1, 32'h0011_2023, 64'h10C, 1, 0);
      #1;
      cmp("sw_imm", 64'(o32Imm), 64'(0));
      cmp("sw_fmt", 64'(o32Fmt), 64'(2));
      cmp("sw_rdwe", 64'(o32RdWe), 64'(0));
      applyStimulus(0, 32'h0, 64'h0, 1, 0);

      $display("[TB] stall with three instructions");
      applyStimulus(1, 32'h00A0_0113, 64'h200, 0, 0);
      applyStimulus(1, 32'h0030_8193, 64'h204, 0, 0);
      #1;
      cmp("stall_ready", 64'(o32InReady), 64'(0));
      applyStimulus(1, 32'h4020_8233, 64'h208, 0, 0);
      applyStimulus(1, 32'h4020_8233, 64'h208, 0, 0);
      applyStimulus(1, 32'h4020_8233, 64'h208, 1, 0);
      applyStimulus(1, 32'h4020_8233, 64'h208, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 64'h0, 1, 0);

      $display("[TB] flush with both entries full");
      applyStimulus(1, 32'h0010_0293, 64'h300, 0, 0);
      applyStimulus(1, 32'h0020_0313, 64'h304, 0, 0);
      applyStimulus(1, 32'h0030_0393, 64'h308, 0, 1);
      #1;
      cmp("flush_valid", 64'(o32Valid), 64'(0));
      cmp("flush_ready", 64'(o32InReady), 64'(1));
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 64'h0, 1, 0);

      $display("[TB] illegal encodings");
      applyStimulus(1, 32'h0000_0000, 64'h400, 1, 0);
      #1;
      cmp("ill0_valid", 64'(o32Valid), 64'(1));
      cmp("ill0_flag", 64'(o32Illegal), 64'(1));
      cmp("ill0_fmt", 64'(o32Fmt), 64'(7));
      cmp("ill0_imm", 64'(o32Imm), 64'(0));
      cmp("ill0_rdwe", 64'(o32RdWe), 64'(0));
      applyStimulus(1, 32'h0000_007F, 64'h404, 1, 0);
      #1;
      cmp("ill7f_flag", 64'(o32Illegal), 64'(1));
      cmp("ill7f_fmt", 64'(o64Fmt), 64'(7));
      cmp("ill7f_rdwe", 64'(o64RdWe), 64'(0));

      $display("[TB] lui x1,0x80000 on both widths");
      applyStimulus(1, 32'h8000_00B7, 64'h500, 1, 0);
      #1;
      cmp("lui64_imm", o64Imm, 64'hFFFF_FFFF_8000_0000);
      cmp("lui32_imm", 64'(o32Imm), 64'h8000_0000);
      applyStimulus(0, 32'h0, 64'h0, 1, 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(logic'($urandom_range(3) != 0), randInstr(),
                       {$urandom, $urandom}, logic'($urandom_range(2) != 0),
                       logic'($urandom_range(20) == 0));
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 64'h0, 1, 0);

      $display("[TB] reset during a stall");
      applyStimulus(1, 32'h0050_0093, 64'h600, 0, 0);
      applyStimulus(1, 32'h0050_0093, 64'h604, 0, 0);
      @(negedge clk);
      #2;
      rst_n   = 1'b0;
      inValid = 1'b0;
      #1;
      checkResetState("midreset");
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 32'h0, 64'h0, 1, 0);
      applyStimulus(1, 32'h0050_0093, 64'h700, 1, 0);
      applyStimulus(0, 32'h0, 64'h0, 1, 0);
      applyStimulus(0, 32'h0, 64'h0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
